// File: rtl/mirror_spi_sender.sv
// mirror_spi_sender: sends {FF, col, row, char, FE} as five SPI bytes, each framed by ss.
// Optional range check enabled by defining MIRROR_SPI_SENDER_RANGE_CHECK_EN.
module mirror_spi_sender #(
    parameter int SCK_HALF   = 512,
    parameter int GAP_CYCLES = 1024
) (
    input  logic       master_clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_col,
    input  logic [7:0] req_row,
    input  logic [7:0] req_char,
    output logic       req_ready,
    output logic       busy,
    output logic       err,
    output logic       s_clk,
    output logic       ss,
    output logic       dataout
);

    localparam int CMAX = (SCK_HALF > GAP_CYCLES) ? SCK_HALF : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SS_SETUP,
        SHIFT,
        SS_HOLD,
        GAP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [2:0]    idx_q;
    logic [7:0]    col_q;
    logic [7:0]    row_q;
    logic [7:0]    char_q;
    logic          sclk_q;
    logic          ss_q;
    logic          dout_q;
    logic          busy_q;
    logic [7:0]    cur_byte;
    logic [7:0]    next_byte;
    logic          reject;

    function automatic logic [7:0] pick(
        input logic [2:0] i,
        input logic [7:0] c,
        input logic [7:0] r,
        input logic [7:0] ch
    );
        case (i)
            3'd0:    pick = 8'hFF;
            3'd1:    pick = c;
            3'd2:    pick = r;
            3'd3:    pick = ch;
            default: pick = 8'hFE;
        endcase
    endfunction

    assign cur_byte  = pick(idx_q, col_q, row_q, char_q);
    assign next_byte = pick(idx_q + 3'd1, col_q, row_q, char_q);

    assign req_ready = (state_q == IDLE) && !reset;
    assign busy      = busy_q;
    assign s_clk     = sclk_q;
    assign ss        = ss_q;
    assign dataout   = dout_q;

`ifdef MIRROR_SPI_SENDER_RANGE_CHECK_EN
    logic err_q;
    assign reject = (req_col >= 8'd40) || (req_row >= 8'd15);
    assign err    = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    // Packet sequencer: all SPI pins and status are registered here.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd7;
            idx_q   <= 3'd0;
            col_q   <= 8'h00;
            row_q   <= 8'h00;
            char_q  <= 8'h00;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MIRROR_SPI_SENDER_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef MIRROR_SPI_SENDER_RANGE_CHECK_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (req_valid && reject) begin
`ifdef MIRROR_SPI_SENDER_RANGE_CHECK_EN
                        err_q <= 1'b1;
`endif
                    end else if (req_valid) begin
                        col_q   <= req_col;
                        row_q   <= req_row;
                        char_q  <= req_char;
                        state_q <= SS_SETUP;
                        ss_q    <= 1'b0;
                        dout_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= 3'd7;
                        idx_q   <= 3'd0;
                    end
                end
                SS_SETUP: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SHIFT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 3'd0) begin
                                state_q <= SS_HOLD;
                            end else begin
                                bit_q  <= bit_q - 3'd1;
                                dout_q <= cur_byte[bit_q - 3'd1];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                SS_HOLD: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        ss_q    <= 1'b1;
                        dout_q  <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd4) begin
                            idx_q   <= 3'd0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            bit_q   <= 3'd7;
                            ss_q    <= 1'b0;
                            dout_q  <= next_byte[7];
                            state_q <= SS_SETUP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
